// File: rtl/common_pkg.sv
// Shared types and constants for the configuration-bus AXI-Lite initiator.
package common_pkg;

  // Transaction sequencing states of the AXI-Lite initiator
  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } cfg_mst_state_e;

  // Read data returned when a transaction is abandoned on timeout
  localparam logic [31:0] CFG_AXIL_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cfg_wdog_timer.sv
// Clear/enable/expire cycle counter used for hung-slave recovery.
// Expired is raised while enabled once LIMIT-1 enabled cycles have elapsed.
module cfg_wdog_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(LIMIT - 1));

  // Count enabled cycles, restart on clear, hold once the limit is reached
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_axil_master.sv
// AXI-Lite initiator for single-beat configuration register requests.
// One transaction outstanding at a time; all m_* outputs are registered.
// Optional hung-slave recovery is enabled by defining CFG_AXIL_TIMEOUT_EN.
module cfg_axil_master
  import common_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(CFG_AXIL_ERR_RDATA)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_aw_valid,
  input  logic                  m_aw_ready,
  output logic [ADDR_WIDTH-1:0] m_aw_addr,
  output logic                  m_w_valid,
  input  logic                  m_w_ready,
  output logic [DATA_WIDTH-1:0] m_w_data,
  input  logic                  m_b_valid,
  output logic                  m_b_ready,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [DATA_WIDTH-1:0] m_r_data
);

  cfg_mst_state_e state, state_next;

  logic                  aw_done, aw_done_next;
  logic                  w_done, w_done_next;
  logic                  rsp_err_q, rsp_err_next;
  logic                  req_ready_next, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_next;
  logic                  aw_valid_next, w_valid_next, ar_valid_next;
  logic                  b_ready_next, r_ready_next;
  logic [ADDR_WIDTH-1:0] aw_addr_next, ar_addr_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  expired;

  assign word_addr = req_addr & ~ADDR_WIDTH'(3);

`ifdef CFG_AXIL_TIMEOUT_EN
  logic wait_state;
  logic in_idle;

  assign wait_state = (state == WR_AW_W) || (state == WR_B) ||
                      (state == RD_AR) || (state == RD_R);
  assign in_idle    = (state == IDLE);

  cfg_wdog_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (in_idle),
    .enable (wait_state),
    .expired(expired)
  );

  assign rsp_err = rsp_err_q;
`else
  logic unused_cfg;

  assign expired    = 1'b0;
  assign rsp_err    = 1'b0;
  assign unused_cfg = rsp_err_q ^ TIMEOUT_CYCLES[0];
`endif

  // Next-state and next-output decode; handshakes are evaluated against the registered valids/readys
  always_comb begin
    state_next     = state;
    aw_done_next   = aw_done;
    w_done_next    = w_done;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err_q;
    aw_valid_next  = m_aw_valid;
    w_valid_next   = m_w_valid;
    ar_valid_next  = m_ar_valid;
    aw_addr_next   = m_aw_addr;
    w_data_next    = m_w_data;
    ar_addr_next   = m_ar_addr;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_write) begin
            state_next    = WR_AW_W;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            aw_addr_next  = word_addr;
            w_data_next   = req_wdata;
            aw_done_next  = 1'b0;
            w_done_next   = 1'b0;
          end else begin
            state_next    = RD_AR;
            ar_valid_next = 1'b1;
            ar_addr_next  = word_addr;
          end
        end
      end
      WR_AW_W: begin
        if (m_aw_valid && m_aw_ready) begin
          aw_valid_next = 1'b0;
          aw_done_next  = 1'b1;
        end
        if (m_w_valid && m_w_ready) begin
          w_valid_next = 1'b0;
          w_done_next  = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          state_next = WR_B;
        end else if (expired) begin
          state_next     = RESP;
          aw_valid_next  = 1'b0;
          w_valid_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
        end
      end
      WR_B: begin
        if (m_b_valid && m_b_ready) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
        end else if (expired) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
        end
      end
      RD_AR: begin
        if (m_ar_valid && m_ar_ready) begin
          state_next    = RD_R;
          ar_valid_next = 1'b0;
        end else if (expired) begin
          state_next     = RESP;
          ar_valid_next  = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = ERR_RDATA;
          rsp_err_next   = 1'b1;
        end
      end
      RD_R: begin
        if (m_r_valid && m_r_ready) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = m_r_data;
          rsp_err_next   = 1'b0;
        end else if (expired) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = ERR_RDATA;
          rsp_err_next   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    b_ready_next   = (state_next == WR_B);
    r_ready_next   = (state_next == RD_R);
    req_ready_next = (state_next == IDLE);
  end

  // State and registered output update; reset clears everything and abandons any transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_err_q  <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      m_aw_valid <= 1'b0;
      m_aw_addr  <= '0;
      m_w_valid  <= 1'b0;
      m_w_data   <= '0;
      m_b_ready  <= 1'b0;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_r_ready  <= 1'b0;
    end else begin
      state      <= state_next;
      aw_done    <= aw_done_next;
      w_done     <= w_done_next;
      rsp_err_q  <= rsp_err_next;
      req_ready  <= req_ready_next;
      rsp_valid  <= rsp_valid_next;
      rsp_rdata  <= rsp_rdata_next;
      m_aw_valid <= aw_valid_next;
      m_aw_addr  <= aw_addr_next;
      m_w_valid  <= w_valid_next;
      m_w_data   <= w_data_next;
      m_b_ready  <= b_ready_next;
      m_ar_valid <= ar_valid_next;
      m_ar_addr  <= ar_addr_next;
      m_r_ready  <= r_ready_next;
    end
  end

endmodule

// File: tb/tb_cfg_axil_master.sv
// Directed testbench for cfg_axil_master. Inputs change and outputs are
// sampled 1 time unit after the rising clock edge.
module tb_cfg_axil_master;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_aw_valid;
  logic        m_aw_ready;
  logic [31:0] m_aw_addr;
  logic        m_w_valid;
  logic        m_w_ready;
  logic [31:0] m_w_data;
  logic        m_b_valid;
  logic        m_b_ready;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_ar_addr;
  logic        m_r_valid;
  logic        m_r_ready;
  logic [31:0] m_r_data;

  int tests_run;
  int tests_failed;

  cfg_axil_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready),
    .m_aw_addr (m_aw_addr),
    .m_w_valid (m_w_valid),
    .m_w_ready (m_w_ready),
    .m_w_data  (m_w_data),
    .m_b_valid (m_b_valid),
    .m_b_ready (m_b_ready),
    .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready),
    .m_ar_addr (m_ar_addr),
    .m_r_valid (m_r_valid),
    .m_r_ready (m_r_ready),
    .m_r_data  (m_r_data)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = '0;
    tick(); tick();
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %0h expected 0", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_err: got %0h expected 0", rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready} !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_m_valid_ready: got %b expected 00000", {m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}); end
    tests_run++; if ({m_aw_addr, m_w_data, m_ar_addr} !== 96'h0) begin tests_failed++; $display("[TB] FAIL reset_m_addr_data: got %h expected 0", {m_aw_addr, m_w_data, m_ar_addr}); end
    rstn = 1'b1;
    tick();
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_req_ready: got %0h expected 1", req_ready); end
  endtask

  task automatic test_write_basic();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0104; req_wdata = 32'hA5A5_0001;
    tick();
    req_valid = 1'b0;
    tests_run++; if ({m_aw_valid, m_w_valid} !== 2'b11) begin tests_failed++; $display("[TB] FAIL wr_aw_w_valid: got %b expected 11", {m_aw_valid, m_w_valid}); end
    tests_run++; if (m_aw_addr !== 32'h0000_0104) begin tests_failed++; $display("[TB] FAIL wr_aw_addr: got %h expected 00000104", m_aw_addr); end
    tests_run++; if (m_w_data !== 32'hA5A5_0001) begin tests_failed++; $display("[TB] FAIL wr_w_data: got %h expected a5a50001", m_w_data); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_req_ready_busy: got %0h expected 0", req_ready); end
    tick();
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready} !== 3'b001) begin tests_failed++; $display("[TB] FAIL wr_after_hs: got aw/w/b %b expected 001", {m_aw_valid, m_w_valid, m_b_ready}); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_rsp_early: got %0h expected 0", rsp_valid); end
    m_b_valid = 1'b1;
    tick();
    m_b_valid = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err, m_b_ready} !== 3'b100) begin tests_failed++; $display("[TB] FAIL wr_rsp_latency: got valid/err/b_ready %b expected 100", {rsp_valid, rsp_err, m_b_ready}); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL wr_rsp_rdata: got %h expected 0", rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++; if ({rsp_valid, req_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL wr_rsp_done: got valid/req_ready %b expected 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_read_wait();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0013;
    tick();
    req_valid = 1'b0;
    tests_run++; if (m_ar_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_ar_valid: got %0h expected 1", m_ar_valid); end
    tests_run++; if (m_ar_addr !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL rd_ar_addr: got %h expected 00000010", m_ar_addr); end
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    tests_run++; if ({m_ar_valid, m_r_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd_after_ar: got ar_valid/r_ready %b expected 01", {m_ar_valid, m_r_ready}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if ({rsp_valid, req_ready, m_r_ready} !== 3'b001) begin tests_failed++; $display("[TB] FAIL rd_wait_%0d: got rsp_valid/req_ready/r_ready %b expected 001", i, {rsp_valid, req_ready, m_r_ready}); end
    end
    m_r_valid = 1'b1; m_r_data = 32'h1234_5678;
    tick();
    m_r_valid = 1'b0; m_r_data = '0;
    tests_run++; if (rsp_rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL rd_rsp_rdata: got %h expected 12345678", rsp_rdata); end
    tests_run++; if ({rsp_valid, rsp_err, req_ready, m_r_ready} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL rd_rsp_flags: got valid/err/req_ready/r_ready %b expected 1000", {rsp_valid, rsp_err, req_ready, m_r_ready}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_req_ready_back: got %0h expected 1", req_ready); end
  endtask

  task automatic test_write_w_first();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0202; req_wdata = 32'h1111_2222;
    tick();
    req_valid = 1'b0;
    tests_run++; if (m_aw_addr !== 32'h0000_0200) begin tests_failed++; $display("[TB] FAIL wf_aw_addr: got %h expected 00000200", m_aw_addr); end
    m_w_ready = 1'b1;
    tick();
    m_w_ready = 1'b0;
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready} !== 3'b100) begin tests_failed++; $display("[TB] FAIL wf_w_dropped: got aw/w/b %b expected 100", {m_aw_valid, m_w_valid, m_b_ready}); end
    tick();
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready} !== 3'b100) begin tests_failed++; $display("[TB] FAIL wf_hold_1: got aw/w/b %b expected 100", {m_aw_valid, m_w_valid, m_b_ready}); end
    tick();
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready} !== 3'b100) begin tests_failed++; $display("[TB] FAIL wf_hold_2: got aw/w/b %b expected 100", {m_aw_valid, m_w_valid, m_b_ready}); end
    m_aw_ready = 1'b1;
    tick();
    m_aw_ready = 1'b0;
    tests_run++; if ({m_aw_valid, m_w_valid, m_b_ready} !== 3'b001) begin tests_failed++; $display("[TB] FAIL wf_both_done: got aw/w/b %b expected 001", {m_aw_valid, m_w_valid, m_b_ready}); end
    m_b_valid = 1'b1;
    tick();
    m_b_valid = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10) begin tests_failed++; $display("[TB] FAIL wf_rsp: got valid/err %b expected 10", {rsp_valid, rsp_err}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
    tick();
    req_valid = 1'b0;
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_data = 32'hCAFE_0001;
    tick();
    m_r_valid = 1'b0; m_r_data = '0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h0000_0005;
    for (int i = 0; i < 10; i++) begin
      tests_run++; if ({rsp_valid, req_ready, m_aw_valid} !== 3'b100 || rsp_rdata !== 32'hCAFE_0001) begin tests_failed++; $display("[TB] FAIL bp_hold_%0d: got valid/req_ready/aw_valid %b rdata %h expected 100 cafe0001", i, {rsp_valid, req_ready, m_aw_valid}, rsp_rdata); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++; if ({rsp_valid, req_ready, m_aw_valid} !== 3'b010) begin tests_failed++; $display("[TB] FAIL bp_after_rsp: got valid/req_ready/aw_valid %b expected 010", {rsp_valid, req_ready, m_aw_valid}); end
    tick();
    req_valid = 1'b0;
    tests_run++; if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h0000_0040) begin tests_failed++; $display("[TB] FAIL bp_new_accept: got aw_valid %0h addr %h expected 1 00000040", m_aw_valid, m_aw_addr); end
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    tick();
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b1;
    tick();
    m_b_valid = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL bp_new_rsp: got valid/err %b rdata %h expected 10 0", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stray_responses();
    m_b_valid = 1'b1; m_r_valid = 1'b1; m_r_data = 32'hFFFF_FFFF;
    tick();
    tick();
    m_b_valid = 1'b0; m_r_valid = 1'b0; m_r_data = '0;
    tests_run++; if ({m_b_ready, m_r_ready, rsp_valid, req_ready} !== 4'b0001) begin tests_failed++; $display("[TB] FAIL stray_ignored: got b_ready/r_ready/rsp_valid/req_ready %b expected 0001", {m_b_ready, m_r_ready, rsp_valid, req_ready}); end
  endtask

`ifdef CFG_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0030;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tests_run++; if ({m_ar_valid, rsp_valid} !== 2'b10) begin tests_failed++; $display("[TB] FAIL to_wait_%0d: got ar_valid/rsp_valid %b expected 10", i, {m_ar_valid, rsp_valid}); end
      tick();
    end
    tests_run++; if ({m_ar_valid, rsp_valid, rsp_err} !== 3'b011) begin tests_failed++; $display("[TB] FAIL to_expire: got ar_valid/rsp_valid/err %b expected 011", {m_ar_valid, rsp_valid, rsp_err}); end
    tests_run++; if (rsp_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL to_rdata: got %h expected deadbeef", rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_back_idle: got %0h expected 1", req_ready); end
  endtask
`else
  task automatic test_no_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0030;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    tests_run++; if ({m_ar_valid, rsp_valid, rsp_err} !== 3'b100) begin tests_failed++; $display("[TB] FAIL nt_still_waiting: got ar_valid/rsp_valid/err %b expected 100", {m_ar_valid, rsp_valid, rsp_err}); end
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 32'h0BAD_F00D;
    tick();
    m_r_valid = 1'b0; m_r_data = '0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BAD_F00D) begin tests_failed++; $display("[TB] FAIL nt_rsp: got valid/err %b rdata %h expected 10 0badf00d", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0050; req_wdata = 32'h7777_8888;
    tick();
    req_valid = 1'b0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    tick();
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    tests_run++; if (m_b_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rm_in_wr_b: got b_ready %0h expected 1", m_b_ready); end
    #2 rstn = 1'b0;
    #1;
    tests_run++; if ({req_ready, rsp_valid, rsp_err, m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready} !== 8'b0) begin tests_failed++; $display("[TB] FAIL rm_async_flags: got %b expected 00000000", {req_ready, rsp_valid, rsp_err, m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}); end
    tests_run++; if ({m_aw_addr, m_w_data, rsp_rdata} !== 96'h0) begin tests_failed++; $display("[TB] FAIL rm_async_data: got %h expected 0", {m_aw_addr, m_w_data, rsp_rdata}); end
    tick();
    rstn = 1'b1;
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0064;
    tick();
    req_valid = 1'b0;
    tests_run++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h0000_0064) begin tests_failed++; $display("[TB] FAIL rm_read_ar: got ar_valid %0h addr %h expected 1 00000064", m_ar_valid, m_ar_addr); end
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 32'h600D_CAFE;
    tick();
    m_r_valid = 1'b0; m_r_data = '0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h600D_CAFE) begin tests_failed++; $display("[TB] FAIL rm_read_rsp: got valid/err %b rdata %h expected 10 600dcafe", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Run all scenarios in order, then report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_w_first();
    test_rsp_backpressure();
    test_stray_responses();
`ifdef CFG_AXIL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
